truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Parameterised, synthesisable exhaustive-stimulus engine for combinational blocks of up to N_IN inputs.
- On start, walks every input vector 0..2^N_IN-1 in ascending order and drives the same vector to the DUT and to a golden reference model.
- After a programmable settle time, compares the DUT and reference responses, counts mismatches and records the first failing vector.
- Emits one trace strobe per vector so a bench or logger can print the truth table row.

Parameters:
- N_IN, 4, number of DUT inputs; vector width; 1..16.
- N_OUT, 1, number of DUT outputs compared; 1..32.
- SETTLE, 1, extra cycles each vector is held before sampling; 0..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- stop_on_fail  in  1  when 1, abort the sweep at the first mismatch; sampled only on an accepted start.
- vec  out  N_IN  stimulus vector to the DUT and reference; bit N_IN-1 is the MSB, i.e. input A.
- dut_resp  in  N_OUT  DUT response to vec.
- ref_resp  in  N_OUT  golden-model response to vec.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; level signal, held until the next accepted start or reset.
- pass  out  1  valid while done=1; 1 when err_cnt==0.
- sample_valid  out  1  one-cycle strobe on each compare cycle.
- sample_mismatch  out  1  valid with sample_valid; 1 when dut_resp!=ref_resp.
- err_cnt  out  N_IN+1  number of mismatching vectors; cannot overflow, since the maximum is 2^N_IN.
- first_fail_vec  out  N_IN  vector of the first mismatch in the sweep.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; vec=0; busy=0; done=0; pass=0; sample_valid=0; sample_mismatch=0; err_cnt=0; first_fail_vec=0; first_fail_valid=0; latched stop flag=0; settle counter=0.
- Reset asserted mid-sweep aborts the sweep immediately: the next edge gives reset values and no done pulse.
- FSM states: IDLE, HOLD, DONE.
  - IDLE: start=1 -> HOLD. The following cycle has vec=0, busy=1 and settle count=0. Counters, first-fail and done/pass are cleared; stop_on_fail is latched.
  - HOLD: vec is held for SETTLE+1 cycles. The compare cycle is the last of these, when settle count==SETTLE.
    - On the compare cycle: sample_valid=1 and sample_mismatch=(dut_resp!=ref_resp) combinationally.
    - At the end of a mismatching compare cycle: err_cnt increments. If first_fail_valid=0, first_fail_vec<=vec and first_fail_valid<=1.
    - After the compare cycle:
      - If vec is all-ones, or a mismatch occurred with the stop flag latched -> DONE.
      - Otherwise vec<=vec+1, settle count<=0.
    - vec never wraps.
  - DONE: busy=0, done=1, pass=(err_cnt==0). vec holds its last value. start=1 -> same action as in IDLE (restart).
- start while busy=1 is ignored, with no effect on the sweep.
- Latency: a full sweep with no abort has busy high for exactly 2^N_IN*(SETTLE+1) cycles; done rises on the cycle after the last compare cycle.
- SETTLE=0: one vector per cycle; sample_valid stays high continuously during the sweep.
- dut_resp and ref_resp are only sampled on compare cycles; their values at other times are don't-care.
- Only N_OUT bits are compared; all bits have equal weight.

Test Plan:
- N_IN=4, N_OUT=1, SETTLE=1, dut_resp=ref_resp=A&B|C&~D; pulse start -> vec steps 0..15, each held 2 cycles; 16 sample_valid strobes; busy high for 32 cycles; done=1, pass=1, err_cnt=0, first_fail_valid=0.
- Same configuration, DUT response forced wrong on vecs 5 and 12, stop_on_fail=0 -> err_cnt=2, first_fail_vec=5, first_fail_valid=1, pass=0; sample_mismatch=1 only on the compare cycles of vecs 5 and 12.
- Same fault, stop_on_fail=1 -> done rises on the cycle after the vec-5 compare cycle; vec holds 5; err_cnt=1; busy high for 12 cycles.
- N_IN=3, SETTLE=0, matching models -> 8 consecutive sample_valid cycles, vec 0..7; done on cycle 9 after start; start pulses while busy change nothing.
- rst_n=0 for one cycle mid-sweep at vec=9 -> next cycle all outputs at reset values, state IDLE. A new start then sweeps from vec=0 with err_cnt restarting at 0.
- Restart from DONE with a previous err_cnt=2 -> on the cycle after start, err_cnt=0, done=0, first_fail_valid=0, vec=0.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive truth-table sweep comparing a DUT against a golden reference
module truth_table_checker #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop_on_fail,
   output logic [N_IN-1:0]   vec,
   input  logic [N_OUT-1:0]  dut_resp,
   input  logic [N_OUT-1:0]  ref_resp,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              sample_valid,
   output logic              sample_mismatch,
   output logic [N_IN:0]     err_cnt,
   output logic [N_IN-1:0]   first_fail_vec,
   output logic              first_fail_valid
);
   typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
   localparam logic [7:0]    SET_MAX = 8'(SETTLE);
   localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
   localparam logic [N_IN:0] ERR_ONE = (N_IN + 1)'(1);
   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic [N_IN-1:0]   vec_nxt, ffv_nxt;
   logic [N_IN:0]     err_nxt;
   logic              ffvalid_nxt, stop_flag, stop_nxt;
   logic              go, mis, last;
   // next-state, datapath updates and status outputs
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      vec_nxt         = vec;
      err_nxt         = err_cnt;
      ffv_nxt         = first_fail_vec;
      ffvalid_nxt     = first_fail_valid;
      stop_nxt        = stop_flag;
      busy            = state == HOLD;
      done            = state == DONE;
      pass            = done && err_cnt == '0;
      go              = start && state != HOLD;
      mis             = dut_resp != ref_resp;
      sample_valid    = busy && cnt == SET_MAX;
      sample_mismatch = sample_valid && mis;
      last            = sample_valid && (&vec || (mis && stop_flag));
      if (go) begin
         state_nxt   = HOLD;
         cnt_nxt     = '0;
         vec_nxt     = '0;
         err_nxt     = '0;
         ffv_nxt     = '0;
         ffvalid_nxt = 1'b0;
         stop_nxt    = stop_on_fail;
      end else if (busy) begin
         if (sample_mismatch) begin
            err_nxt     = err_cnt + ERR_ONE;
            ffv_nxt     = first_fail_valid ? first_fail_vec : vec;
            ffvalid_nxt = 1'b1;
         end
         if (last)
            state_nxt = DONE;
         else if (sample_valid) begin
            vec_nxt = vec + VEC_ONE;
            cnt_nxt = '0;
         end else
            cnt_nxt = cnt + 8'd1;
      end
   end
   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= '0;
         vec              <= '0;
         err_cnt          <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         stop_flag        <= 1'b0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt_nxt;
         vec              <= vec_nxt;
         err_cnt          <= err_nxt;
         first_fail_vec   <= ffv_nxt;
         first_fail_valid <= ffvalid_nxt;
         stop_flag        <= stop_nxt;
      end
   end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed-vector bench for the truth-table sweep engine
module tb_truth_table_checker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start4 = 1'b0, start3 = 1'b0, stop = 1'b0, fault = 1'b0;
   logic [3:0] vec4;
   logic [2:0] vec3;
   logic       ref4, dut4;
   logic [1:0] ref3;
   logic       busy4, done4, pass4, sv4, sm4, ffval4;
   logic [4:0] err4;
   logic [3:0] ffv4;
   logic       busy3, done3, pass3, sv3, sm3, ffval3;
   logic [3:0] err3;
   logic [2:0] ffv3;
   int         checks = 0, errors = 0;
   always #5 clk = ~clk;
   assign ref4 = (vec4[3] & vec4[2]) | (vec4[1] & ~vec4[0]);
   assign dut4 = ref4 ^ (fault && (vec4 == 4'd5 || vec4 == 4'd12));
   assign ref3 = {^vec3, vec3[2] & vec3[0]};
   truth_table_checker #(.N_IN(4), .N_OUT(1), .SETTLE(1)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .stop_on_fail(stop), .vec(vec4),
      .dut_resp(dut4), .ref_resp(ref4), .busy(busy4), .done(done4), .pass(pass4),
      .sample_valid(sv4), .sample_mismatch(sm4), .err_cnt(err4),
      .first_fail_vec(ffv4), .first_fail_valid(ffval4));
   truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE(0)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .stop_on_fail(1'b0), .vec(vec3),
      .dut_resp(ref3), .ref_resp(ref3), .busy(busy3), .done(done3), .pass(pass3),
      .sample_valid(sv3), .sample_mismatch(sm3), .err_cnt(err3),
      .first_fail_vec(ffv3), .first_fail_valid(ffval3));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse4(input logic s);
      stop   = s;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
   endtask
   // follows an SETTLE=1 sweep already in its first busy cycle; returns busy length and strobe count
   task automatic watch4(output int cyc, output int strobes);
      cyc = 0;
      strobes = 0;
      while (busy4 && cyc < 100) begin
         check("vec4", vec4, cyc / 2);
         check("sv4", sv4, cyc % 2);
         check("sm4", sm4, (cyc % 2 == 1) && fault && (cyc / 2 == 5 || cyc / 2 == 12));
         strobes += sv4;
         step();
         cyc++;
      end
   endtask
   initial begin
      int cyc, strobes;
      step();
      step();
      check("rst_vec", vec4, 0);
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_pass", pass4, 0);
      check("rst_sv", sv4, 0);
      check("rst_err", err4, 0);
      check("rst_ffval", ffval4, 0);
      rst_n = 1'b1;
      step();
      pulse4(1'b0);
      watch4(cyc, strobes);
      check("clean_busy_len", cyc, 32);
      check("clean_strobes", strobes, 16);
      check("clean_done", done4, 1);
      check("clean_pass", pass4, 1);
      check("clean_err", err4, 0);
      check("clean_ffval", ffval4, 0);
      check("clean_vec_hold", vec4, 15);
      fault = 1'b1;
      pulse4(1'b0);
      watch4(cyc, strobes);
      check("fault_busy_len", cyc, 32);
      check("fault_err", err4, 2);
      check("fault_ffv", ffv4, 5);
      check("fault_ffval", ffval4, 1);
      check("fault_pass", pass4, 0);
      check("fault_done", done4, 1);
      pulse4(1'b1);
      check("restart_err", err4, 0);
      check("restart_done", done4, 0);
      check("restart_ffval", ffval4, 0);
      check("restart_vec", vec4, 0);
      check("restart_busy", busy4, 1);
      watch4(cyc, strobes);
      check("stop_busy_len", cyc, 12);
      check("stop_done", done4, 1);
      check("stop_vec", vec4, 5);
      check("stop_err", err4, 1);
      check("stop_ffv", ffv4, 5);
      check("stop_pass", pass4, 0);
      fault = 1'b1;
      pulse4(1'b0);
      cyc = 0;
      while (vec4 != 4'd9 && cyc < 100) begin
         step();
         cyc++;
      end
      check("reach_vec9", vec4, 9);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_vec", vec4, 0);
      check("midrst_busy", busy4, 0);
      check("midrst_done", done4, 0);
      check("midrst_pass", pass4, 0);
      check("midrst_sv", sv4, 0);
      check("midrst_err", err4, 0);
      check("midrst_ffv", ffv4, 0);
      check("midrst_ffval", ffval4, 0);
      step();
      check("idle_busy", busy4, 0);
      check("idle_done", done4, 0);
      fault = 1'b0;
      pulse4(1'b0);
      check("resweep_vec", vec4, 0);
      check("resweep_err", err4, 0);
      watch4(cyc, strobes);
      check("resweep_busy_len", cyc, 32);
      check("resweep_pass", pass4, 1);
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check("s0_vec", vec3, k - 1);
         check("s0_sv", sv3, 1);
         check("s0_busy", busy3, 1);
         check("s0_sm", sm3, 0);
         start3 = (k == 3 || k == 6);
         step();
         start3 = 1'b0;
      end
      check("s0_done", done3, 1);
      check("s0_busy_end", busy3, 0);
      check("s0_pass", pass3, 1);
      check("s0_err", err3, 0);
      check("s0_vec_hold", vec3, 7);
      step();
      check("s0_done_held", done3, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
